// File: rtl/queue_pop_mux.sv
// Pop steering for the arbitrated queue FIFOs plus a 2-entry valid/ready output buffer.
// Optional per-queue saturating pop counters when QPOP_STATS_EN is defined.
//
// state | meaning
// EMPTY | no word buffered, valid_out low
// ONE   | head entry holds a word
// TWO   | head and tail both hold words, new pops blocked by credit
module queue_pop_mux #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int DATA_BITS      = 8,
    parameter int SEL_BITS       = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enb,
    input  logic [SEL_BITS-1:0]                 selector,
    input  logic                                out_enb,
    input  logic [QUEUE_QUANTITY-1:0]           buf_empty,
    input  logic [QUEUE_QUANTITY*DATA_BITS-1:0] data_in,
    output logic [QUEUE_QUANTITY-1:0]           pop,
    output logic [DATA_BITS-1:0]                data_out,
    output logic                                valid_out,
    input  logic                                out_ready
`ifdef QPOP_STATS_EN
    ,
    output logic [QUEUE_QUANTITY*16-1:0]        pop_count
`endif
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_e;

    occ_e                state_q, state_d;
    logic                inflight_q, inflight_d;
    logic [SEL_BITS-1:0] sel_q, sel_d;
    logic [DATA_BITS-1:0] head_q, head_d;
    logic [DATA_BITS-1:0] tail_q, tail_d;

    logic                 deq;
    logic                 capture;
    logic                 credit;
    logic                 any_pop;
    logic [2:0]           pending;
    logic [DATA_BITS-1:0] cap_word;

    // Credit counts the word still in flight from the FIFO so the buffer can never overflow.
    always_comb begin
        deq     = valid_out & out_ready;
        capture = inflight_q;
        pending = {1'b0, state_q} + {2'b00, inflight_q};
        credit  = pending < (3'd2 + {2'b00, deq});
        for (int i = 0; i < QUEUE_QUANTITY; i++) begin
            pop[i] = rst & enb & out_enb & (selector == SEL_BITS'(i)) & ~buf_empty[i] & credit;
        end
        any_pop  = |pop;
        cap_word = '0;
        for (int i = 0; i < QUEUE_QUANTITY; i++) begin
            if (sel_q == SEL_BITS'(i)) cap_word = data_in[i*DATA_BITS +: DATA_BITS];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= EMPTY;
            inflight_q <= 1'b0;
            sel_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            sel_q      <= sel_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (capture) state_d = ONE;
            ONE: begin
                if (capture && !deq)      state_d = TWO;
                else if (!capture && deq) state_d = EMPTY;
            end
            TWO:     if (deq && !capture) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        valid_out = (state_q != EMPTY);
        data_out  = head_q;
    end

    // Datapath: head always holds the oldest word; tail only used in TWO.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        inflight_d = any_pop;
        sel_d      = any_pop ? selector : sel_q;
        case (state_q)
            EMPTY: if (capture) head_d = cap_word;
            ONE: begin
                if (capture) begin
                    if (deq) head_d = cap_word;
                    else     tail_d = cap_word;
                end
            end
            TWO: begin
                if (deq) begin
                    head_d = tail_q;
                    if (capture) tail_d = cap_word;
                end
            end
            default: ;
        endcase
    end

`ifdef QPOP_STATS_EN
    logic [QUEUE_QUANTITY-1:0][15:0] cnt_q, cnt_d;

    always_comb begin
        for (int i = 0; i < QUEUE_QUANTITY; i++) begin
            cnt_d[i] = cnt_q[i];
            if (pop[i] && (cnt_q[i] != 16'hFFFF)) cnt_d[i] = cnt_q[i] + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign pop_count = cnt_q;
`endif

endmodule
